// File: rtl/avalon_read_master.sv
// Avalon-MM pipelined read master.
// Credit-gated issue into a return FIFO drained by a valid/ready stream.
module avalon_read_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int DMA_ADDR_WIDTH = 24,
  parameter int LEN_WIDTH      = 16,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DMA_ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]      length,
  output logic                      busy,
  output logic                      done,
  output logic [DMA_ADDR_WIDTH-1:0] avm_address,
  output logic                      avm_read,
  output logic [3:0]                avm_byteenable,
  output logic                      avm_burstcount,
  input  logic                      avm_waitrequest,
  input  logic [DATA_WIDTH-1:0]     avm_readdata,
  input  logic                      avm_readdatavalid,
  output logic [DATA_WIDTH-1:0]     st_data,
  output logic                      st_valid,
  input  logic                      st_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         pending;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;
  logic [LEN_WIDTH-1:0]  received;

  logic                  xfer;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [CW-1:0]         count_nxt;
  logic [CW-1:0]         pending_nxt;
  logic [CW:0]           credit_sum;
  logic                  credit_ok;
  logic [LEN_WIDTH-1:0]  issued_nxt;

  assign avm_byteenable = 4'hF;
  assign avm_burstcount = 1'b1;
  assign st_data        = mem[rd_ptr];
  assign st_valid       = (fifo_count != '0);

  always_comb begin
    xfer        = (state == ISSUE) || (state == DRAIN);
    accept      = avm_read & ~avm_waitrequest;
    push        = avm_readdatavalid & xfer;
    pop         = st_valid & st_ready;
    count_nxt   = fifo_count + CW'(push) - CW'(pop);
    pending_nxt = pending + CW'(accept) - CW'(push);
    issued_nxt  = issued + LEN_WIDTH'(accept);
    // in-flight reads plus buffered words must leave a free slot
    credit_sum  = {1'b0, pending_nxt} + {1'b0, count_nxt};
    credit_ok   = (credit_sum < DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= avm_readdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      avm_address <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      pending     <= '0;
      len_q       <= '0;
      issued      <= '0;
      received    <= '0;
    end else begin
      done       <= 1'b0;
      fifo_count <= count_nxt;
      pending    <= pending_nxt;
      received   <= received + LEN_WIDTH'(push);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q       <= length;
            avm_address <= start_addr & ~DMA_ADDR_WIDTH'(3);
            issued      <= '0;
            received    <= '0;
            busy        <= 1'b1;
            if (length == '0) begin
              state <= FINISH;
            end else begin
              state    <= ISSUE;
              avm_read <= 1'b1;
            end
          end
        end
        ISSUE: begin
          issued <= issued_nxt;
          if (accept) begin
            avm_address <= avm_address + DMA_ADDR_WIDTH'(4);
          end
          if (accept && issued_nxt == len_q) begin
            state    <= DRAIN;
            avm_read <= 1'b0;
          end else begin
            avm_read <= (avm_read & ~accept) | credit_ok;
          end
        end
        DRAIN: begin
          if (received == len_q && fifo_count == '0) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_read_master.sv
// Bench for avalon_read_master: slave model with random stalls and latency,
// scoreboard derived from start address arithmetic.
module tb_avalon_read_master;

  localparam int DW    = 32;
  localparam int AW    = 24;
  localparam int LW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic [3:0]    avm_byteenable;
  logic          avm_burstcount;
  logic          avm_waitrequest = 1'b0;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic [DW-1:0] st_data;
  logic          st_valid;
  logic          st_ready = 1'b0;

  always #5 clk = ~clk;

  avalon_read_master #(
    .DATA_WIDTH(DW),
    .DMA_ADDR_WIDTH(AW),
    .LEN_WIDTH(LW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .start_addr(start_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .st_data(st_data),
    .st_valid(st_valid),
    .st_ready(st_ready)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } ret_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    int            lat;
    int            wait_pct;
    int            ready_pct;
    bit            chk_thru;
    logic [AW-1:0] exp_last;
  } vec_t;

  ret_t rq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int lat_min = 1;
  int lat_max = 1;
  int wait_pct = 0;
  int ready_pct = 100;
  int rst_cycles = 0;
  bit start_req = 0;
  logic [AW-1:0] start_a = '0;
  logic [LW-1:0] start_len = '0;
  logic [AW-1:0] stall_addr = '0;
  int stall_left = 0;
  int stall_seen = 0;

  logic [AW-1:0] base = '0;
  int xlen = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int first_acc = 0;
  int last_acc_cyc = 0;
  int max_occ = 0;
  int late_rdv = 0;
  int last_due = 0;
  logic [AW-1:0] last_acc_addr = '0;

  function automatic logic [DW-1:0] mem_fn(logic [AW-1:0] a);
    return {a, 8'h5A} ^ 32'hC0FFEE11;
  endfunction

  function automatic logic [AW-1:0] addr_of(int i);
    return base + AW'(4 * i);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic step();
    int lat;
    int due;
    @(negedge clk);
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_low_at_done", 64'(busy), 64'd0);
    end
    reset = (rst_cycles > 0);
    if (rst_cycles > 0) rst_cycles--;
    start = start_req;
    if (start_req) start_cyc = cyc;
    start_req  = 0;
    start_addr = start_a;
    length     = start_len;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = rq[0].data;
      void'(rq.pop_front());
      if (!busy) late_rdv++;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
    end
    if (reset) begin
      avm_waitrequest = 1'b1;
    end else if (avm_read && avm_address == stall_addr && stall_left > 0) begin
      avm_waitrequest = 1'b1;
      stall_left--;
      stall_seen++;
    end else begin
      avm_waitrequest = (int'($urandom_range(99)) < wait_pct);
    end
    st_ready = !reset && (int'($urandom_range(99)) < ready_pct);
    if (!reset && avm_read && !avm_waitrequest) begin
      chk("read_addr", 64'(avm_address), 64'(addr_of(acc_cnt)));
      if (acc_cnt == 0) first_acc = cyc;
      last_acc_cyc  = cyc;
      last_acc_addr = avm_address;
      lat = int'($urandom_range(lat_max, lat_min));
      due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = due;
      rq.push_back('{mem_fn(avm_address), due});
      acc_cnt++;
    end
    if (!reset && st_valid && st_ready) begin
      chk("st_data", 64'(st_data), 64'(mem_fn(addr_of(pop_cnt))));
      pop_cnt++;
    end
    if (acc_cnt - pop_cnt > max_occ) max_occ = acc_cnt - pop_cnt;
  endtask

  task automatic begin_xfer(logic [AW-1:0] a, int len);
    base      = a & ~AW'(3);
    xlen      = len;
    acc_cnt   = 0;
    pop_cnt   = 0;
    done_cnt  = 0;
    max_occ   = 0;
    first_acc = 0;
    start_a   = a;
    start_len = LW'(len);
    start_req = 1;
    step();
    step();
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    chk("done_seen", 64'(done_cnt > 0), 64'd1);
  endtask

  task automatic end_xfer(logic [AW-1:0] exp_last);
    repeat (3) step();
    chk("acc_count", 64'(acc_cnt), 64'(xlen));
    chk("pop_count", 64'(pop_cnt), 64'(xlen));
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("occupancy", 64'(max_occ <= DEPTH), 64'd1);
    chk("idle_read", 64'(avm_read), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    if (xlen > 0) chk("last_addr", 64'(last_acc_addr), 64'(exp_last));
  endtask

  vec_t vecs[5];

  initial begin
    int n;
    int acc_hold;
    int sv_seen;
    vecs[0] = '{24'h000100,  4, 1,  0, 100, 1'b1, 24'h00010C};
    vecs[1] = '{24'hFFFFFC,  2, 1,  0, 100, 1'b1, 24'h000000};
    vecs[2] = '{24'h123457,  3, 2,  0, 100, 1'b0, 24'h12345C};
    vecs[3] = '{24'h000000,  1, 3, 30,  60, 1'b0, 24'h000000};
    vecs[4] = '{24'hABCDE0, 16, 3, 20,  50, 1'b0, 24'hABCE1C};

    rst_cycles = 2;
    step();
    step();
    step();
    chk("rst_read", 64'(avm_read), 64'd0);
    chk("rst_addr", 64'(avm_address), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(st_valid), 64'd0);
    chk("byteenable", 64'(avm_byteenable), 64'hF);
    chk("burstcount", 64'(avm_burstcount), 64'd1);

    for (int i = 0; i < 5; i++) begin
      lat_min   = 1;
      lat_max   = vecs[i].lat;
      wait_pct  = vecs[i].wait_pct;
      ready_pct = vecs[i].ready_pct;
      begin_xfer(vecs[i].addr, vecs[i].len);
      wait_done(1000);
      end_xfer(vecs[i].exp_last);
      if (vecs[i].chk_thru)
        chk("back_to_back", 64'(last_acc_cyc - first_acc),
            64'(vecs[i].len - 1));
    end

    lat_min = 1; lat_max = 1; wait_pct = 0; ready_pct = 100;
    stall_addr = 24'h000104;
    stall_left = 3;
    stall_seen = 0;
    begin_xfer(24'h000100, 4);
    wait_done(200);
    end_xfer(24'h00010C);
    chk("stall_held", 64'(stall_seen), 64'd3);

    begin_xfer(24'h000200, 0);
    wait_done(20);
    end_xfer(24'h0);
    chk("zero_len_timing", 64'(done_cyc - start_cyc), 64'd2);

    lat_min = 1; lat_max = 3; ready_pct = 0;
    begin_xfer(24'h000400, 20);
    repeat (30) step();
    chk("credit_accepts", 64'(acc_cnt), 64'd8);
    chk("credit_read_low", 64'(avm_read), 64'd0);
    chk("credit_no_pop", 64'(pop_cnt), 64'd0);
    chk("credit_returned", 64'(rq.size()), 64'd0);
    chk("credit_valid", 64'(st_valid), 64'd1);
    ready_pct = 100;
    wait_done(500);
    end_xfer(24'h00044C);

    lat_min = 4; lat_max = 4;
    begin_xfer(24'h002000, 10);
    n = 0;
    while (pop_cnt < 3 && n < 200) begin
      step();
      n++;
    end
    chk("rst_mid_reach", 64'(pop_cnt >= 3), 64'd1);
    rst_cycles = 1;
    done_cnt = 0;
    late_rdv = 0;
    step();
    acc_hold = acc_cnt;
    step();
    chk("mid_rst_read", 64'(avm_read), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(st_valid), 64'd0);
    sv_seen = 0;
    n = 0;
    while ((rq.size() > 0 || n < 4) && n < 50) begin
      step();
      if (st_valid) sv_seen++;
      n++;
    end
    chk("late_rdv_seen", 64'(late_rdv > 0), 64'd1);
    chk("late_rdv_dropped", 64'(sv_seen), 64'd0);
    chk("no_done_after_rst", 64'(done_cnt), 64'd0);
    chk("no_read_after_rst", 64'(acc_cnt), 64'(acc_hold));
    lat_min = 1; lat_max = 3;
    begin_xfer(24'h003000, 5);
    wait_done(200);
    end_xfer(24'h003010);

    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] a;
      int len;
      a         = AW'($urandom);
      len       = int'($urandom_range(40, 1));
      lat_min   = 1;
      lat_max   = int'($urandom_range(6, 1));
      wait_pct  = int'($urandom_range(50, 0));
      ready_pct = int'($urandom_range(100, 20));
      begin_xfer(a, len);
      wait_done(3000);
      end_xfer((a & ~AW'(3)) + AW'(4 * (len - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
